// File: rtl/piece_queue.sv
// piece_queue: 7-bag tetromino generator feeding a head + preview shift queue.
// Define PIECE_QUEUE_HOLD_EN to enable the swap-with-hold slot.
module piece_queue #(
    parameter int          PREVIEW_DEPTH = 3,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          PIECE_W       = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start_i,
    input  logic                               pop_i,
    output logic [PIECE_W-1:0]                 next_o,
    output logic                               next_valid_o,
    output logic [PIECE_W*PREVIEW_DEPTH-1:0]   preview_o,
    output logic [PREVIEW_DEPTH-1:0]           preview_valid_o,
    input  logic                               hold_req_i,
    output logic [PIECE_W-1:0]                 hold_o,
    output logic                               hold_valid_o,
    output logic                               busy_o
);

    localparam int Q  = PREVIEW_DEPTH + 1;
    localparam int CW = $clog2(Q + 1);

    typedef enum logic [1:0] {IDLE, FILL, READY} state_t;

    state_t             state;
    logic [15:0]        lfsr;
    logic [15:0]        lfsr_nxt;
    logic [6:0]         mask;
    logic [6:0]         mask_nxt;
    logic [CW-1:0]      count;
    logic [CW-1:0]      count_nxt;
    logic [CW-1:0]      wr_idx;
    logic [PIECE_W-1:0] slots     [Q];
    logic [PIECE_W-1:0] slots_nxt [Q];

    logic [2:0]         cand;
    logic [2:0]         pick;
    logic [2:0]         pick_hi;
    logic [2:0]         pick_lo;
    logic               hi_found;

    logic               pop_ok;
    logic               hold_ok;
    logic               hold_take;
    logic               hold_swap;
    logic               shift;
    logic               push;
    logic [PIECE_W-1:0] hold_q;
    logic               hold_valid_q;

    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    // Bag draw: first remaining piece at or above the candidate, else the lowest remaining one.
    always_comb begin
        cand     = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
        pick_hi  = 3'd0;
        pick_lo  = 3'd0;
        hi_found = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (mask[i]) begin
                pick_lo = 3'(i);
                if (3'(i) >= cand) begin
                    pick_hi  = 3'(i);
                    hi_found = 1'b1;
                end
            end
        end
        pick     = hi_found ? pick_hi : pick_lo;
        mask_nxt = mask & ~(7'b1 << pick);
        if (mask_nxt == 7'h00) begin
            mask_nxt = 7'h7F;
        end
    end

    always_comb begin
        pop_ok    = pop_i && (count != '0);
        hold_take = hold_ok && !hold_valid_q;
        hold_swap = hold_ok && hold_valid_q;
        shift     = pop_ok || hold_take;
        push      = (state == FILL) && (count < CW'(Q));
        wr_idx    = shift ? (count - 1'b1) : count;
        count_nxt = count + CW'(push) - CW'(shift);
        for (int k = 0; k < Q; k++) begin
            slots_nxt[k] = slots[k];
        end
        if (shift) begin
            for (int k = 0; k < Q - 1; k++) begin
                slots_nxt[k] = slots[k+1];
            end
            slots_nxt[Q-1] = '0;
        end
        if (hold_swap) begin
            slots_nxt[0] = hold_q;
        end
        if (push) begin
            slots_nxt[wr_idx] = pick;
        end
    end

    // start_i overrides everything except the LFSR, which keeps running to avoid repeating bags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= SEED;
            mask  <= 7'h7F;
            count <= '0;
            for (int k = 0; k < Q; k++) begin
                slots[k] <= '0;
            end
        end else begin
            if (state != IDLE) begin
                lfsr <= lfsr_nxt;
            end
            if (start_i) begin
                state <= FILL;
                mask  <= 7'h7F;
                count <= '0;
                for (int k = 0; k < Q; k++) begin
                    slots[k] <= '0;
                end
            end else begin
                for (int k = 0; k < Q; k++) begin
                    slots[k] <= slots_nxt[k];
                end
                count <= count_nxt;
                if (push) begin
                    mask <= mask_nxt;
                end
                case (state)
                    FILL:    if (count_nxt == CW'(Q)) state <= READY;
                    READY:   if (shift) state <= FILL;
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef PIECE_QUEUE_HOLD_EN
    logic hold_used;

    assign hold_ok = hold_req_i && next_valid_o && !hold_used && !pop_i;

    // One hold per piece: hold_used is re-armed only by a real pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_used    <= 1'b0;
        end else if (start_i) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_used    <= 1'b0;
        end else begin
            if (hold_ok) begin
                hold_q    <= slots[0];
                hold_used <= 1'b1;
            end else if (pop_ok) begin
                hold_used <= 1'b0;
            end
            if (hold_take) begin
                hold_valid_q <= 1'b1;
            end
        end
    end
`else
    logic unused_hold_req;

    assign unused_hold_req = hold_req_i;
    assign hold_ok         = 1'b0;
    assign hold_q          = '0;
    assign hold_valid_q    = 1'b0;
`endif

    assign next_o       = slots[0];
    assign next_valid_o = (count != '0);
    assign hold_o       = hold_q;
    assign hold_valid_o = hold_valid_q;
    assign busy_o       = (state == FILL);

    genvar gk;
    generate
        for (gk = 1; gk <= PREVIEW_DEPTH; gk++) begin : g_preview
            assign preview_o[PIECE_W*gk-1 -: PIECE_W] = slots[gk];
            assign preview_valid_o[gk-1]              = (count > CW'(gk));
        end
    endgenerate

endmodule

// File: tb/tb_piece_queue.sv
// Testbench for piece_queue: cycle-level reference model of LFSR, bag and queue
// feeding a scoreboard queue; hold checks follow PIECE_QUEUE_HOLD_EN.
module tb_piece_queue;

    localparam int PD = 3;
    localparam int Q  = PD + 1;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          pop_i;
    logic [2:0]    next_o;
    logic          next_valid_o;
    logic [3*PD-1:0] preview_o;
    logic [PD-1:0] preview_valid_o;
    logic          hold_req_i;
    logic [2:0]    hold_o;
    logic          hold_valid_o;
    logic          busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum {M_IDLE, M_FILL, M_READY} mstate_t;
    mstate_t     m_state;
    logic [15:0] m_lfsr;
    logic [6:0]  m_mask;
    logic [2:0]  sb[$];
    logic [2:0]  m_hold;
    logic        m_hold_valid;
    logic        m_hold_used;

    piece_queue #(.PREVIEW_DEPTH(PD), .SEED(16'hACE1), .PIECE_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .pop_i          (pop_i),
        .next_o         (next_o),
        .next_valid_o   (next_valid_o),
        .preview_o      (preview_o),
        .preview_valid_o(preview_valid_o),
        .hold_req_i     (hold_req_i),
        .hold_o         (hold_o),
        .hold_valid_o   (hold_valid_o),
        .busy_o         (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [PD-1:0] exp_pv();
        logic [PD-1:0] v;
        for (int k = 1; k <= PD; k++) v[k-1] = (sb.size() > k);
        return v;
    endfunction

    task automatic model_reset();
        m_state      = M_IDLE;
        m_lfsr       = 16'hACE1;
        m_mask       = 7'h7F;
        m_hold       = 3'd0;
        m_hold_valid = 1'b0;
        m_hold_used  = 1'b0;
        sb.delete();
    endtask

    // Predicts the effect of the coming rising edge for the given inputs.
    task automatic model_edge(input logic st, input logic pp, input logic hr);
        logic       adv, pop_ok, hold_ok, take, swap, push, shifted;
        logic [2:0] cand, pick, tmp;
        int         idx;
        adv  = (m_state != M_IDLE);
        push = (m_state == M_FILL) && (sb.size() < Q);
        cand = (m_lfsr[2:0] == 3'd7) ? 3'd0 : m_lfsr[2:0];
        pick = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            idx = (int'(cand) + i) % 7;
            if (m_mask[idx]) pick = 3'(idx);
        end
        pop_ok = pp && (sb.size() > 0);
`ifdef PIECE_QUEUE_HOLD_EN
        hold_ok = hr && (sb.size() > 0) && !m_hold_used && !pp;
`else
        hold_ok = hr & 1'b0;
`endif
        if (st) begin
            sb.delete();
            m_mask       = 7'h7F;
            m_hold       = 3'd0;
            m_hold_valid = 1'b0;
            m_hold_used  = 1'b0;
            m_state      = M_FILL;
        end else begin
            take    = hold_ok && !m_hold_valid;
            swap    = hold_ok && m_hold_valid;
            shifted = pop_ok || take;
            if (shifted) begin
                tmp = sb.pop_front();
                if (take) begin
                    m_hold       = tmp;
                    m_hold_valid = 1'b1;
                end
            end
            if (swap) begin
                tmp    = sb[0];
                sb[0]  = m_hold;
                m_hold = tmp;
            end
            if (hold_ok) m_hold_used = 1'b1;
            if (pop_ok)  m_hold_used = 1'b0;
            if (push) begin
                sb.push_back(pick);
                m_mask[pick] = 1'b0;
                if (m_mask == 7'h00) m_mask = 7'h7F;
            end
            if (m_state == M_FILL && sb.size() == Q) m_state = M_READY;
            else if (m_state == M_READY && shifted)  m_state = M_FILL;
        end
        if (adv) m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic tick(input logic st, input logic pp, input logic hr);
        start_i    = st;
        pop_i      = pp;
        hold_req_i = hr;
        model_edge(st, pp, hr);
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        pop_i      = 1'b0;
        hold_req_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; pop_i = 1'b0; hold_req_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (next_o !== 3'd0 || next_valid_o !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_head: got %0d/%0b expected 0/0", next_o, next_valid_o);
        end
        n_cmp++;
        if (preview_o !== '0 || preview_valid_o !== '0) begin
            n_bad++; $display("[TB] FAIL reset_preview: got %h/%b expected 0/0", preview_o, preview_valid_o);
        end
        n_cmp++;
        if (hold_o !== 3'd0 || hold_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_misc: hold %0d/%0b busy %0b expected all 0", hold_o, hold_valid_o, busy_o);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_idle_pop();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if ({next_o, next_valid_o, preview_o, preview_valid_o, busy_o} !== '0) begin
            n_bad++; $display("[TB] FAIL idle_pop: head %0d/%0b preview %h/%b busy %0b expected all 0",
                              next_o, next_valid_o, preview_o, preview_valid_o, busy_o);
        end
    endtask

    task automatic test_fill();
        tick(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (next_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL start_edge: valid %0b busy %0b expected 0 1", next_valid_o, busy_o);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (next_valid_o !== 1'b1 || next_o !== 3'd1) begin
            n_bad++; $display("[TB] FAIL first_piece: got %0d valid %0b expected 1 valid 1", next_o, next_valid_o);
        end
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy_o !== 1'b1 || preview_valid_o !== 3'b011) begin
            n_bad++; $display("[TB] FAIL three_pushes: busy %0b pv %b expected 1 011", busy_o, preview_valid_o);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy_o !== 1'b0 || preview_valid_o !== 3'b111) begin
            n_bad++; $display("[TB] FAIL full: busy %0b pv %b expected 0 111", busy_o, preview_valid_o);
        end
        n_cmp++;
        if ({preview_o, next_o} !== {sb[3], sb[2], sb[1], sb[0]}) begin
            n_bad++; $display("[TB] FAIL full_contents: got %h expected %h", {preview_o, next_o},
                              {sb[3], sb[2], sb[1], sb[0]});
        end
    endtask

    task automatic test_bag();
        logic [2:0] got [14];
        logic [6:0] seen;
        logic [2:0] exp;
        for (int i = 0; i < 14; i++) begin
            n_cmp++;
            if (next_valid_o !== 1'b1) begin
                n_bad++; $display("[TB] FAIL bag_valid[%0d]: got %0b expected 1", i, next_valid_o);
            end
            exp = sb[0];
            n_cmp++;
            if (next_o !== exp) begin
                n_bad++; $display("[TB] FAIL bag_pop[%0d]: got %0d expected %0d", i, next_o, exp);
            end
            got[i] = next_o;
            tick(1'b0, 1'b1, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        for (int g = 0; g < 2; g++) begin
            seen = 7'h00;
            for (int i = 0; i < 7; i++) begin
                if (got[g*7+i] != 3'd7) seen[got[g*7+i]] = 1'b1;
            end
            n_cmp++;
            if (seen !== 7'h7F) begin
                n_bad++; $display("[TB] FAIL bag_perm[%0d]: got mask %h expected 7f", g, seen);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        for (int i = 0; i < 10; i++) begin
            exp = sb[0];
            n_cmp++;
            if (next_valid_o !== 1'b1 || next_o !== exp) begin
                n_bad++; $display("[TB] FAIL b2b_head[%0d]: got %0d/%0b expected %0d/1", i, next_o, next_valid_o, exp);
            end
            n_cmp++;
            if (preview_valid_o !== exp_pv() || preview_valid_o[1] !== 1'b1) begin
                n_bad++; $display("[TB] FAIL b2b_count[%0d]: pv %b expected %b", i, preview_valid_o, exp_pv());
            end
            for (int k = 1; k <= PD; k++) begin
                if (sb.size() > k) begin
                    n_cmp++;
                    if (preview_o[3*k-1 -: 3] !== sb[k]) begin
                        n_bad++; $display("[TB] FAIL b2b_slot[%0d][%0d]: got %0d expected %0d",
                                          i, k, preview_o[3*k-1 -: 3], sb[k]);
                    end
                end
            end
            tick(1'b0, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (busy_o !== 1'b0 || preview_valid_o !== 3'b111) begin
            n_bad++; $display("[TB] FAIL b2b_refill: busy %0b pv %b expected 0 111", busy_o, preview_valid_o);
        end
    endtask

    task automatic test_restart();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (next_valid_o !== 1'b0 || preview_valid_o !== '0 || busy_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL restart_flush: valid %0b pv %b busy %0b expected 0 000 1",
                              next_valid_o, preview_valid_o, busy_o);
        end
        for (int i = 0; i < Q; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            n_cmp++;
            if (next_valid_o !== 1'b1 || next_o !== sb[0] || preview_valid_o !== exp_pv()) begin
                n_bad++; $display("[TB] FAIL restart_refill[%0d]: head %0d pv %b expected %0d %b",
                                  i, next_o, preview_valid_o, sb[0], exp_pv());
            end
        end
        n_cmp++;
        if (busy_o !== 1'b0 || {preview_o, next_o} !== {sb[3], sb[2], sb[1], sb[0]}) begin
            n_bad++; $display("[TB] FAIL restart_full: busy %0b contents %h expected 0 %h", busy_o,
                              {preview_o, next_o}, {sb[3], sb[2], sb[1], sb[0]});
        end
    endtask

    task automatic test_hold();
`ifdef PIECE_QUEUE_HOLD_EN
        logic [2:0] h0, hd;
        h0 = sb[0];
        tick(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (hold_o !== h0 || hold_valid_o !== 1'b1 || next_o !== sb[0]) begin
            n_bad++; $display("[TB] FAIL hold_take: hold %0d/%0b head %0d expected %0d/1 head %0d",
                              hold_o, hold_valid_o, next_o, h0, sb[0]);
        end
        tick(1'b0, 1'b0, 1'b0);
        hd = sb[0];
        tick(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (hold_o !== h0 || next_o !== hd) begin
            n_bad++; $display("[TB] FAIL hold_again: hold %0d head %0d expected %0d %0d", hold_o, next_o, h0, hd);
        end
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        hd = sb[0];
        tick(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (next_o !== h0 || hold_o !== hd || hold_valid_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL hold_swap: head %0d hold %0d expected %0d %0d", next_o, hold_o, h0, hd);
        end
        n_cmp++;
        if (preview_valid_o !== exp_pv()) begin
            n_bad++; $display("[TB] FAIL hold_swap_count: pv %b expected %b", preview_valid_o, exp_pv());
        end
`else
        logic [2:0] hd;
        hd = sb[0];
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (hold_valid_o !== 1'b0 || hold_o !== 3'd0) begin
            n_bad++; $display("[TB] FAIL hold_disabled: got %0d/%0b expected 0/0", hold_o, hold_valid_o);
        end
        n_cmp++;
        if (next_o !== hd || preview_valid_o !== 3'b111) begin
            n_bad++; $display("[TB] FAIL hold_disabled_head: head %0d pv %b expected %0d 111", next_o, preview_valid_o, hd);
        end
`endif
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({next_o, next_valid_o, preview_valid_o, busy_o, hold_valid_o} !== '0) begin
            n_bad++; $display("[TB] FAIL async_reset: head %0d/%0b pv %b busy %0b expected all 0",
                              next_o, next_valid_o, preview_valid_o, busy_o);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (next_o !== 3'd1 || next_o !== sb[0] || next_valid_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL reseed: got %0d valid %0b expected 1 valid 1", next_o, next_valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_idle_pop();
        test_fill();
        test_bag();
        test_back_to_back();
        test_restart();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/piece_queue.md
Name: piece_queue

Overview:
- Tetromino generator and preview queue for the game core.
- Draws pieces from a 7-bag randomiser driven by a 16-bit Galois LFSR, so each bag of 7 draws contains every block_t exactly once.
- Buffers the current piece plus PREVIEW_DEPTH upcoming pieces for the spawn logic and the preview renderer.
- Generalises the fixed piece enumeration into a parametrised, self-refilling stream.

Parameters:
- PREVIEW_DEPTH, 3, number of preview slots after the head; queue depth Q = PREVIEW_DEPTH+1; legal range 1..6.
- SEED, 16'hACE1, LFSR reset value; must be non-zero.
- PIECE_W, 3, width of one block_t code; fixed at 3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse: flush queue, reload bag, begin filling.
- pop_i  in  1  consumer takes the head piece.
- next_o  out  3  head piece (block_t encoding, I_CYAN=0 .. Z_RED=6).
- next_valid_o  out  1  head slot holds a valid piece.
- preview_o  out  3*PREVIEW_DEPTH  slots 1..PREVIEW_DEPTH; slot k in bits [3k-1:3k-3].
- preview_valid_o  out  PREVIEW_DEPTH  per-slot valid.
- hold_req_i  in  1  swap-with-hold request (feature-gated).
- hold_o  out  3  held piece.
- hold_valid_o  out  1  hold slot occupied.
- busy_o  out  1  FSM in FILL.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All outputs 0; queue count 0; bag mask 7'h7F; LFSR = SEED; FSM IDLE.
  - Hold empty; hold_used 0.
- LFSR:
  - 16-bit Galois, right shift: next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
  - Advances every cycle in FILL or READY, regardless of draws.
- Draw:
  - cand = lfsr[2:0]; cand==7 is treated as 0.
  - pick = first set mask bit at index >= cand, wrapping to 0.
  - Single-cycle combinational search.
  - On push, clear mask[pick]. If the mask becomes 0, reload it to 7'h7F in the same cycle.
- FSM:
  - IDLE: start_i -> FILL.
  - FILL: push one piece per cycle while count<Q. When count reaches Q -> READY.
  - READY: pop_i -> FILL next cycle, so the vacated slot refills with 1-cycle latency.
- start_i in any state:
  - Count := 0, mask := 7F, hold cleared, go to FILL.
  - LFSR is not reseeded.
  - start_i has priority over pop_i and hold_req_i in the same cycle.
- Latency: start_i sampled at edge N -> first push at edge N+1 -> next_valid_o high after edge N+1. Queue full after Q pushes.
- Queue:
  - Shift structure; head is slot 0. Pop shifts all slots down by one.
  - Push writes slot count (or count-1 when a pop occurs in the same cycle).
  - Pop and push in the same cycle: count unchanged, order preserved.
- Boundaries:
  - pop_i with count==0 is ignored, no underflow.
  - No push when count==Q.
  - preview_valid_o[k-1] = (count > k).
- busy_o = (state==FILL).
- Reset asserted mid-FILL: immediate return to the reset values above.

Optional Feature:
- Macro PIECE_QUEUE_HOLD_EN.
- Defined:
  - hold_req_i is accepted when next_valid_o=1, hold_used=0 and pop_i=0.
  - If hold is empty: hold := head, head popped (refills as for pop), hold_valid_o := 1.
  - Else: head and hold swap in place, count unchanged.
  - Either case sets hold_used := 1; pop_i clears it.
  - hold_req_i with hold_used=1 is ignored.
- Not defined: hold_req_i ignored; hold_o=0, hold_valid_o=0 constantly; ports still present.

Test Plan:
- Reset, SEED=16'hACE1, PREVIEW_DEPTH=3, pulse start_i -> next_valid_o high one edge later with next_o=1 (J_BLUE, lfsr[2:0]=001). After 4 pushes, busy_o=0 and preview_valid_o=3'b111.
- Pop 14 times, one pop per 2 cycles, after fill -> each consecutive group of 7 popped values, aligned to bag reload, is a permutation of 0..6. No pop ever sees next_valid_o=0.
- pop_i every cycle from the full state -> count holds at 3 or 4, order preserved. Scoreboard against a reference model of the LFSR and bag.
- pop_i with count=0 (before start) -> no state change; outputs stay 0.
- start_i asserted mid-FILL with pop_i=1 -> queue flushed, mask 7F, refill restarts. LFSR continues from its current value, not SEED.
- With PIECE_QUEUE_HOLD_EN, head=2:
  - hold_req_i -> hold_o=2, hold_valid_o=1, head advances.
  - Second hold_req_i before pop -> ignored.
  - After pop_i, hold_req_i with head=5 -> head=2, hold_o=5.
  - Without the macro -> hold_valid_o stays 0.
